// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths, read-side FSM
// encoding and the binary-to-Gray helper.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } rd_state_e;

  // The caller zero-extends the pointer into 32 bits and truncates the result.
  function automatic logic [31:0] b2g(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/g2b.sv
// Gray-to-binary decoder. Each binary bit is the XOR of all Gray bits at or above it.
module g2b #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] gray_i,
  output logic [SIZE-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: owns the read pointer, fetches words
// from the dual-port RAM and presents them as a first-word-fall-through valid/ready stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AE_THRESH = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDR_W:0]   wptr_gray_s,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W:0]   rd_level,
  output logic              almost_empty,
  output logic              ptr_err
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

  rd_state_e     state_q, state_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_gray_q;
  logic [PW-1:0] rd_level_q;
  logic          almost_empty_q;
  logic          ptr_err_q;

  logic [PW-1:0] wbin;
  logic [PW-1:0] level;
  logic [PW-1:0] level_post;
  logic          avail;
  logic          ren;

  g2b #(.SIZE(PW)) u_wptr_g2b (
    .gray_i (wptr_gray_s),
    .bin_o  (wbin)
  );

  // Modulo subtraction handles pointer wrap; a write landing in the same cycle as a
  // read is already folded into wbin.
  assign level = wbin - rbin_q;
  assign avail = (level != '0);

  // NOTE: every always_comb output gets a default before the case, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (avail) begin
          ren     = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (dout_ready) begin
          if (avail) ren = 1'b1;
          else       state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    rbin_d = ren ? rbin_q + PW'(1) : rbin_q;
  end

  assign level_post = level - PW'(ren);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values and simulation matches the synthesised hardware.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q        <= ST_EMPTY;
      rbin_q         <= '0;
      rptr_gray_q    <= '0;
      rd_level_q     <= '0;
      almost_empty_q <= 1'b1;
      ptr_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rbin_q         <= rbin_d;
      rptr_gray_q    <= PW'(b2g(32'(rbin_d)));
      rd_level_q     <= level_post;
      almost_empty_q <= (level_post <= AE_P);
      ptr_err_q      <= ptr_err_q | (level > DEPTH_P);
    end
  end

  // While reset is held the FSM sits in EMPTY, yet a stale write pointer may still look
  // non-empty; gating with rrst_n keeps the RAM idle until release.
  assign ram_ren      = ren & rrst_n;
  assign ram_raddr    = rbin_q[ADDR_W-1:0];
  assign dout         = ram_rdata;
  assign dout_valid   = (state_q == ST_VALID);
  assign rptr_gray    = rptr_gray_q;
  assign rd_level     = rd_level_q;
  assign almost_empty = almost_empty_q;
  assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a registered-read RAM model preloaded with 0x30+addr.
module tb_fifo_rd_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              rclk;
  logic              rrst_n;
  logic [ADDR_W:0]   wptr_gray_s;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W:0]   rd_level;
  logic              almost_empty;
  logic              ptr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [16];

  fifo_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AE_THRESH(2)) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .wptr_gray_s  (wptr_gray_s),
    .ram_raddr    (ram_raddr),
    .ram_ren      (ram_ren),
    .ram_rdata    (ram_rdata),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .rptr_gray    (rptr_gray),
    .rd_level     (rd_level),
    .almost_empty (almost_empty),
    .ptr_err      (ptr_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n      = 1'b0;
    wptr_gray_s = '0;
    dout_ready  = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge rclk);
      #1;
      if (!dout_valid && !ram_ren) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, done, 1);
  endtask

  logic [3:0] wrap_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
  // 5-bit pointers: rbin 31, 32->0, 33->1, 34->2 give Gray 0x10, 0x00, 0x01, 0x03.
  logic [4:0] wrap_gray [4] = '{5'h10, 5'h00, 5'h01, 5'h03};

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
    ram_rdata   = '0;
    rrst_n      = 1'b0;
    wptr_gray_s = '0;
    dout_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge rclk);
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_ren", ram_ren, 0);
    check("rst_gray", rptr_gray, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_level", rd_level, 0);
    check("rst_err", ptr_err, 0);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Single word: fetched the cycle it appears, visible one cycle later
    @(negedge rclk);
    wptr_gray_s = 5'h01;
    dout_ready  = 1'b1;
    #1;
    check("one_ren", ram_ren, 1);
    check("one_raddr", ram_raddr, 0);
    check("one_valid_pre", dout_valid, 0);
    @(negedge rclk);
    #1;
    check("one_valid", dout_valid, 1);
    check("one_dout", dout, 8'h30);
    check("one_gray", rptr_gray, 5'h01);
    check("one_ren_idle", ram_ren, 0);
    check("one_level", rd_level, 0);
    @(negedge rclk);
    #1;
    check("one_empty", dout_valid, 0);

    // Full FIFO: 16 back-to-back reads
    do_reset();
    @(negedge rclk);
    wptr_gray_s = 5'h18;
    dout_ready  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("full_ren", ram_ren, 1);
      check("full_raddr", ram_raddr, 32'(k));
      if (k > 0) begin
        check("full_valid", dout_valid, 1);
        check("full_dout", dout, 32'(8'h30 + k - 1));
        check("full_level", rd_level, 32'(16 - k));
        check("full_ae", almost_empty, ((16 - k) <= 2) ? 1 : 0);
      end
      @(negedge rclk);
    end
    #1;
    check("full_ren_end", ram_ren, 0);
    check("full_dout_last", dout, 8'h3F);
    check("full_level_end", rd_level, 0);
    check("full_ae_end", almost_empty, 1);
    @(negedge rclk);
    #1;
    check("full_empty", dout_valid, 0);

    // Backpressure: rbin=16, three words available
    @(negedge rclk);
    wptr_gray_s = 5'h1A;
    dout_ready  = 1'b0;
    #1;
    check("bp_ren0", ram_ren, 1);
    check("bp_raddr0", ram_raddr, 0);
    repeat (5) begin
      @(negedge rclk);
      #1;
      check("bp_hold_ren", ram_ren, 0);
      check("bp_hold_valid", dout_valid, 1);
      check("bp_hold_dout", dout, 8'h30);
      check("bp_hold_level", rd_level, 2);
    end
    dout_ready = 1'b1;
    #1;
    check("bp_resume_ren", ram_ren, 1);
    check("bp_resume_raddr", ram_raddr, 1);
    @(negedge rclk);
    #1;
    check("bp_dout1", dout, 8'h31);
    check("bp_raddr2", ram_raddr, 2);
    @(negedge rclk);
    #1;
    check("bp_dout2", dout, 8'h32);
    check("bp_ren_end", ram_ren, 0);
    check("bp_level_end", rd_level, 0);
    @(negedge rclk);
    #1;
    check("bp_empty", dout_valid, 0);

    // Wrap: advance rbin 19 -> 30, then write pointer at 34 (mod 32 = 2)
    @(negedge rclk);
    wptr_gray_s = 5'h11;
    drain("wrap_pre_drain");
    check("wrap_gray30", rptr_gray, 5'h11);
    @(negedge rclk);
    wptr_gray_s = 5'h03;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("wrap_ren", ram_ren, 1);
      check("wrap_raddr", ram_raddr, wrap_addr[k]);
      @(negedge rclk);
      #1;
      check("wrap_gray", rptr_gray, wrap_gray[k]);
    end
    check("wrap_ren_end", ram_ren, 0);
    check("wrap_dout_last", dout, 8'h31);

    // Pointer error: level 20 > depth 16, sticky
    do_reset();
    @(negedge rclk);
    wptr_gray_s = 5'h1E;
    dout_ready  = 1'b1;
    #1;
    check("err_pre", ptr_err, 0);
    @(negedge rclk);
    #1;
    check("err_set", ptr_err, 1);
    repeat (5) @(negedge rclk);
    #1;
    check("err_sticky", ptr_err, 1);
    check("err_burst_valid", dout_valid, 1);
    check("err_burst_ren", ram_ren, 1);

    // Async reset mid-burst, no clock edge in between
    rrst_n = 1'b0;
    #1;
    check("arst_valid", dout_valid, 0);
    check("arst_ren", ram_ren, 0);
    check("arst_gray", rptr_gray, 0);
    check("arst_level", rd_level, 0);
    check("arst_ae", almost_empty, 1);
    check("arst_err", ptr_err, 0);
    check("arst_raddr", ram_raddr, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
